// File: rtl/axi_ethernet_v3_01_a_sync_filter_if.sv
// Bundles the per-bit synchroniser data path: async input bits and the
// filtered level, edge pulses and change flag presented in the clk domain.
interface axi_ethernet_v3_01_a_sync_filter_if #(
    parameter int WIDTH = 1
);
    // No valid/ready handshake: data_in is a free-running level sampled every
    // clk edge, and every output is valid on every cycle once reset is released.
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output data_in,
        input  data_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  data_in,
        output data_out,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/axi_ethernet_v3_01_a_sync_filter.sv
// Per-bit CDC synchroniser: flop chain, consecutive-mismatch glitch filter and
// registered rise/fall/changed pulses. Bits are fully independent.
module axi_ethernet_v3_01_a_sync_filter #(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] INITIALISE    = '0,
    parameter int               FILTER_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    axi_ethernet_v3_01_a_sync_filter_if.slave bus
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    // Pure flop-to-flop chain so the ASYNC_REG group stays intact.
    always_comb begin
        sync_d[0] = bus.data_in;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[STAGES-1][i] != data_out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    data_out_d[i] = sync_q[STAGES-1][i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        rise_d    = data_out_d & ~data_out_q;
        fall_d    = ~data_out_d & data_out_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= INITIALISE;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            data_out_q <= INITIALISE;
            rise_q     <= '0;
            fall_q     <= '0;
            changed_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            data_out_q <= data_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            changed_q  <= changed_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.changed  = changed_q;
endmodule

// File: tb/tb_axi_ethernet_v3_01_a_sync_filter.sv
// Three synchroniser configurations share one random input stream; a window
// model of the filter feeds an expected queue checked by a negedge monitor.
module tb_axi_ethernet_v3_01_a_sync_filter;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] din = 4'b0000;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    axi_ethernet_v3_01_a_sync_filter_if #(.WIDTH(4)) if0 ();
    axi_ethernet_v3_01_a_sync_filter_if #(.WIDTH(4)) if1 ();
    axi_ethernet_v3_01_a_sync_filter_if #(.WIDTH(4)) if2 ();
    assign if0.data_in = din;
    assign if1.data_in = din;
    assign if2.data_in = din;

    axi_ethernet_v3_01_a_sync_filter #(.WIDTH(4), .STAGES(2), .INITIALISE(4'b1010), .FILTER_CYCLES(1))
        dut0 (.clk(clk), .resetn(resetn), .bus(if0));
    axi_ethernet_v3_01_a_sync_filter #(.WIDTH(4), .STAGES(2), .INITIALISE(4'b0000), .FILTER_CYCLES(4))
        dut1 (.clk(clk), .resetn(resetn), .bus(if1));
    axi_ethernet_v3_01_a_sync_filter #(.WIDTH(4), .STAGES(4), .INITIALISE(4'b0011), .FILTER_CYCLES(8))
        dut2 (.clk(clk), .resetn(resetn), .bus(if2));

    function automatic int st(int k);
        return (k == 2) ? 4 : 2;
    endfunction
    function automatic int fc(int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction
    function automatic logic [3:0] ini(int k);
        return (k == 0) ? 4'b1010 : ((k == 1) ? 4'b0000 : 4'b0011);
    endfunction

    // Expected entry: {dut id[1:0], changed, fall[3:0], rise[3:0], data_out[3:0]}
    logic [14:0] exp_q[$];
    logic [3:0]  pipe [3][5];
    logic [3:0]  hist [3][8];
    int          hist_n [3];
    logic [3:0]  mout [3];
    int          exp_pulses [3];
    int          act_pulses [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 5; s++) pipe[k][s] = ini(k);
            hist_n[k] = 0;
            mout[k]   = ini(k);
        end
        exp_q.delete();
    endtask

    // A bit updates only when the last fc() synchronised samples since reset
    // all disagree with the current output level.
    task automatic model_step(int k);
        logic [3:0] s, nxt, r, f;
        logic       all_diff;
        s   = pipe[k][st(k)-1];
        nxt = mout[k];
        if (hist_n[k] < 8) begin
            hist[k][hist_n[k]] = s;
            hist_n[k]++;
        end else begin
            for (int j = 0; j < 7; j++) hist[k][j] = hist[k][j+1];
            hist[k][7] = s;
        end
        for (int b = 0; b < 4; b++) begin
            if (hist_n[k] >= fc(k)) begin
                all_diff = 1'b1;
                for (int j = hist_n[k] - fc(k); j < hist_n[k]; j++) begin
                    if (hist[k][j][b] == mout[k][b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = s[b];
            end
        end
        r = nxt & ~mout[k];
        f = ~nxt & mout[k];
        mout[k] = nxt;
        for (int j = st(k) - 1; j > 0; j--) pipe[k][j] = pipe[k][j-1];
        pipe[k][0] = din;
        exp_q.push_back({2'(k), |(r | f), f, r, nxt});
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else for (int k = 0; k < 3; k++) model_step(k);
    end

    function automatic logic [12:0] actual(int k);
        case (k)
            0:       return {if0.changed, if0.fall, if0.rise, if0.data_out};
            1:       return {if1.changed, if1.fall, if1.rise, if1.data_out};
            default: return {if2.changed, if2.fall, if2.rise, if2.data_out};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [14:0] e;
        logic [12:0] a;
        if (resetn) begin
            for (int k = 0; k < 3; k++) begin
                a = actual(k);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty dut%0d actual=%h required=entry", k, a);
                end else begin
                    e = exp_q.pop_front();
                    if (e[14:13] != 2'(k) || e[12:0] != a) begin
                        failures++;
                        $display("FAIL sb_dut%0d {chg,fall,rise,out} actual=%h required=%h (tag %0d) t=%0t",
                                 k, a, e[12:0], e[14:13], $time);
                    end
                    exp_pulses[k] += $countones(e[11:4]);
                end
                act_pulses[k] += $countones(a[11:4]);
            end
        end
    end

    task automatic chk(string name, logic [12:0] act, logic [12:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reset asserted mid-cycle must force outputs without any clock edge.
    task automatic mid_reset(int hold);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("async_reset_dut%0d", k), actual(k), {9'd0, ini(k)});
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic drive(logic [3:0] v, int cycles);
        @(negedge clk);
        din = v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            exp_pulses[k] = 0;
            act_pulses[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_state_dut%0d", k), actual(k), {9'd0, ini(k)});
        @(negedge clk);
        #2 resetn = 1'b1;

        drive(4'b0001, 14);          // single bit latency
        drive(4'b0011, 3);           // 3-cycle glitch on bit 1
        drive(4'b0001, 12);
        drive(4'b0011, 14);          // held long enough for every filter
        drive(4'b0000, 14);
        drive(4'b0101, 16);          // simultaneous toggle
        drive(4'b1010, 5 + 4);       // five mismatch cycles past dut2's chain
        mid_reset(2);
        drive(4'b1010, 16);          // re-converge after reset with din differing
        mid_reset(1);

        for (int n = 0; n < 250; n++) begin
            drive(4'($urandom), $urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) mid_reset($urandom_range(0, 3));
        end
        drive(4'($urandom), 20);
        repeat (3) @(negedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_pulses[k] != exp_pulses[k]) begin
                failures++;
                $display("FAIL pulse_count_dut%0d actual=%0d required=%0d", k, act_pulses[k], exp_pulses[k]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
